// File: rtl/alu_pkg.sv
// Shared ALU control codes, engine state encoding and default datapath width.
// Imported by the ALU control decoder and by the execute-stage ALU.
package alu_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MFHI = 4'b0011;
    localparam logic [3:0] ALU_MFLO = 4'b0100;
    localparam logic [3:0] ALU_MULT = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_DIV  = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } eng_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed MULT/DIV engine owning the architectural HI/LO registers.
// Latency: start at E0 -> HI/LO and done valid after E(DATA_W+1); DIV by zero pulses done after E0.
// Backpressure: none; start is ignored while busy, the controller must stall on busy.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_mult,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    eng_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] p_hi, p_lo, opd;
    logic              div_op, neg_a, neg_b;

    logic              b_nz, accept, reject;
    logic [DATA_W-1:0] a_abs, b_abs;
    logic [DATA_W:0]   mul_add;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W-1:0] div_diff;
    logic              div_ge;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0] quo_fix, rem_fix;

    assign b_nz   = |b;
    assign accept = start && (state == ST_IDLE) && (is_mult || (is_div && b_nz));
    assign reject = start && (state == ST_IDLE) && is_div && !b_nz;
    assign a_abs  = a[DATA_W-1] ? -a : a;
    assign b_abs  = b[DATA_W-1] ? -b : b;

    // MULT: p_hi accumulates, p_lo holds the multiplier and collects product low bits.
    assign mul_add = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opd} : {(DATA_W+1){1'b0}});

    // DIV: p_hi is the partial remainder, p_lo shifts dividend out and quotient in.
    assign div_shift = {p_hi, p_lo[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, opd};
    assign div_diff  = div_shift[DATA_W-1:0] - opd;

    assign prod     = {p_hi, p_lo};
    assign prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    assign quo_fix  = (neg_a ^ neg_b) ? -p_lo : p_lo;
    assign rem_fix  = neg_a ? -p_hi : p_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == LAST_STEP) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            p_hi        <= '0;
            p_lo        <= '0;
            opd         <= '0;
            div_op      <= 1'b0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        div_op <= is_div;
                        neg_a  <= a[DATA_W-1];
                        neg_b  <= b[DATA_W-1];
                        p_hi   <= '0;
                        p_lo   <= is_div ? a_abs : b_abs;
                        opd    <= is_div ? b_abs : a_abs;
                    end else if (reject) begin
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (div_op) begin
                        p_hi <= div_ge ? div_diff : div_shift[DATA_W-1:0];
                        p_lo <= {p_lo[DATA_W-2:0], div_ge};
                    end else begin
                        p_hi <= mul_add[DATA_W:1];
                        p_lo <= {mul_add[0], p_lo[DATA_W-1:1]};
                    end
                end
                ST_FIN: begin
                    if (div_op) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*DATA_W-1:DATA_W];
                        lo <= prod_fix[DATA_W-1:0];
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_hilo.sv
// Execute-stage ALU: combinational logic/arith ops plus HI/LO reads, with an iterative MULT/DIV engine.
// Latency: result/zero are combinational; MULT/DIV complete DATA_W+2 cycles after start.
// Backpressure: busy tells the controller to stall; no interlock on MFHI/MFLO while busy.
module alu_hilo
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              start,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero
);

    logic [DATA_W-1:0] hi, lo;

    muldiv_seq #(.DATA_W(DATA_W)) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_mult     (alu_ctrl == ALU_MULT),
        .is_div      (alu_ctrl == ALU_DIV),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_NOR:  result = ~(a | b);
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_MFHI: result = hi;
            ALU_MFLO: result = lo;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_alu_hilo.sv
// Directed self-checking bench for alu_hilo with hand-computed expectations.
module tb_alu_hilo;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_ctrl;
    logic [31:0] a, b;
    logic        start;
    logic [31:0] result;
    logic        zero, busy, done, div_by_zero;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    alu_hilo #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_ctrl    (alu_ctrl),
        .a           (a),
        .b           (b),
        .start       (start),
        .result      (result),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic comb(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        alu_ctrl = c; a = x; b = y;
        #1;
    endtask

    // Launch at the current negedge, return cycles until done is seen; ends in the done cycle.
    task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                          output int n);
        alu_ctrl = c; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; alu_ctrl = ALU_MFHI; a = '0; b = '0; start = 1'b0;
        step(); step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        check("rst_hi", result, 32'd0);
        comb(ALU_MFLO, 0, 0);
        check("rst_lo", result, 32'd0);
        rst = 1'b0;
        step();

        comb(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        check("add", result, 32'h8000_0000);
        check("add_zero", {31'b0, zero}, 32'd0);
        comb(ALU_SUB, 32'd5, 32'd5);
        check("sub", result, 32'd0);
        check("sub_zero", {31'b0, zero}, 32'd1);
        comb(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg", result, 32'd1);
        comb(ALU_SLT, 32'd1, 32'hFFFF_FFFF);
        check("slt_pos", result, 32'd0);
        comb(ALU_NOR, 32'd0, 32'd0);
        check("nor", result, 32'hFFFF_FFFF);
        comb(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("and", result, 32'h00F0_1200);
        comb(ALU_OR, 32'hF000_0001, 32'h0000_0100);
        check("or", result, 32'hF000_0101);
        comb(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("undef", result, 32'd0);
        comb(ALU_MULT, 32'd3, 32'd4);
        check("mult_res", result, 32'd0);
        step();

        // MULT -3 x 7 with explicit busy check on the first cycle
        alu_ctrl = ALU_MULT; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        check("mult_busy", {31'b0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 200) begin step(); lat++; end
        check("mult_lat", lat, 34);
        check("mult_busy_done", {31'b0, busy}, 32'd0);
        comb(ALU_MFLO, 0, 0);
        check("mult_lo", result, 32'hFFFF_FFEB);
        comb(ALU_MFHI, 0, 0);
        check("mult_hi", result, 32'hFFFF_FFFF);
        step();

        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lat", lat, 34);
        comb(ALU_MFLO, 0, 0);
        check("div_lo", result, 32'hFFFF_FFFD);
        comb(ALU_MFHI, 0, 0);
        check("div_hi", result, 32'hFFFF_FFFF);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        comb(ALU_MFLO, 0, 0);
        check("divmin_lo", result, 32'h8000_0000);
        comb(ALU_MFHI, 0, 0);
        check("divmin_hi", result, 32'd0);
        step();

        alu_ctrl = ALU_DIV; a = 32'd9; b = 32'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("dz_done", {31'b0, done}, 32'd1);
        check("dz_flag", {31'b0, div_by_zero}, 32'd1);
        check("dz_busy", {31'b0, busy}, 32'd0);
        comb(ALU_MFLO, 0, 0);
        check("dz_lo", result, 32'h8000_0000);
        comb(ALU_MFHI, 0, 0);
        check("dz_hi", result, 32'd0);
        step();
        check("dz_done_off", {31'b0, done}, 32'd0);
        check("dz_flag_off", {31'b0, div_by_zero}, 32'd0);

        run_op(ALU_MULT, 32'hFFFF_FFFF, 32'd1, lat);
        step();
        alu_ctrl = ALU_MULT; a = 32'd100; b = 32'd200; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        step(); step(); lat += 2;
        alu_ctrl = ALU_MULT; a = 32'd5; b = 32'd5; start = 1'b1;
        step(); lat++;
        start = 1'b0;
        comb(ALU_MFHI, 0, 0);
        check("stale_hi", result, 32'hFFFF_FFFF);
        while (!done && lat < 200) begin step(); lat++; end
        check("ign_lat", lat, 34);
        comb(ALU_MFLO, 0, 0);
        check("ign_lo", result, 32'd20000);
        comb(ALU_MFHI, 0, 0);
        check("ign_hi", result, 32'd0);
        // back-to-back launch from the done cycle
        run_op(ALU_MULT, 32'h0001_0000, 32'h0001_0000, lat);
        check("b2b_lat", lat, 34);
        comb(ALU_MFLO, 0, 0);
        check("b2b_lo", result, 32'd0);
        comb(ALU_MFHI, 0, 0);
        check("b2b_hi", result, 32'd1);
        step();

        alu_ctrl = ALU_MULT; a = 32'd123; b = 32'd456; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (lat < 10) begin step(); lat++; end
        alu_ctrl = ALU_MFHI;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_hi", result, 32'd0);
        comb(ALU_MFLO, 0, 0);
        check("arst_lo", result, 32'd0);
        step();
        rst = 1'b0;
        step();
        run_op(ALU_MULT, 32'd2, 32'd3, lat);
        check("post_lat", lat, 34);
        comb(ALU_MFLO, 0, 0);
        check("post_lo", result, 32'd6);
        comb(ALU_MFHI, 0, 0);
        check("post_hi", result, 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    always @(negedge clk) begin
        if (!rst && busy && done) begin
            n_cmp++;
            n_err++;
            $error("FAIL busy_done_overlap: observed busy=1 done=1 required not both");
        end
    end

endmodule

// File: doc/alu_hilo.md
# alu_hilo

Execute-stage ALU consuming the 4-bit operation code produced by the ALU control decoder, plus the two register operands. AND/OR/NOR/ADD/SUB/SLT and MFHI/MFLO complete combinationally. MULT and DIV run on an iterative engine that writes the architectural HI/LO registers. A busy/done handshake lets the main controller stall the pipeline while the engine runs.

## Interface
- `DATA_W`, default 32: operand/result width; the iteration count equals `DATA_W`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `alu_ctrl`, input, 4: operation code.
  - 0000 AND, 0001 OR, 1100 NOR, 0010 ADD, 0110 SUB, 0111 SLT.
  - 1000 DIV, 0101 MULT, 0011 MFHI, 0100 MFLO.
- `a`, input, `DATA_W`: operand A (rs); dividend or multiplicand.
- `b`, input, `DATA_W`: operand B (rt/immediate); divisor or multiplier.
- `start`, input, 1: launch MULT/DIV; qualified by `alu_ctrl` and the engine being idle.
- `result`, output, `DATA_W`: combinational result.
- `zero`, output, 1: `result == 0`; used for beq.
- `busy`, output, 1: engine running.
- `done`, output, 1: one-cycle pulse when HI/LO are updated or a DIV is rejected.
- `div_by_zero`, output, 1: one-cycle pulse, coincident with `done`, for DIV with `b == 0`.

## Operation
- **Combinational ops**
  - ADD/SUB: modulo 2^DATA_W; no overflow detection.
  - SLT: signed compare; result is 1 or 0.
  - NOR: ~(a|b).
  - MFHI/MFLO: `result` = current HI/LO register value.
  - MULT, DIV and undefined codes: `result` = 0.
- **Engine FSM**: IDLE → RUN → FIN → IDLE.
  - IDLE: on `start` with MULT, or DIV with `b != 0`, capture |a|, |b| and the sign bits; clear the counter; go to RUN.
  - RUN: one shift-add (MULT) or one restoring-subtract (DIV) step per cycle. After `DATA_W` steps, go to FIN.
  - FIN: apply sign correction, write HI/LO, pulse `done`, go to IDLE.
- **MULT**: {HI,LO} = signed 64-bit product of a and b.
- **DIV**: signed.
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / −1 gives LO = 0x80000000, HI = 0.
- **DIV with `b == 0`**:
  - No state change; HI/LO unchanged.
  - `done` and `div_by_zero` pulse in the following cycle.
- **Ignored cases**
  - `start` while RUN/FIN is ignored.
  - `start` with a non-MULT/DIV code is ignored.
- **Stale reads**: MFHI/MFLO while `busy` returns the previous HI/LO. The controller must stall on `busy`; this block does not interlock.

## Timing
- **Reset** (asynchronous): state = IDLE, HI = LO = 0, counter = 0, `busy` = `done` = `div_by_zero` = 0.
  - A reset mid-operation aborts the engine and clears HI/LO immediately.
- **Latency** (`start` sampled at edge E0):
  - `busy` = 1 from after E0 until after E(`DATA_W`+1).
  - HI/LO written, and `done` = 1, for the cycle after E(`DATA_W`+1). For `DATA_W` = 32 this is 34 cycles after the start cycle.
- **`busy`/`done` relationship**: `busy` and `done` are never both 1.
- **MFHI/MFLO in the `done` cycle**: returns the new values.
- **Back-to-back**: a `start` in the `done` cycle is accepted, with no bubble.
- **Outputs**: `result` and `zero` are purely combinational from `alu_ctrl`, `a`, `b`, HI and LO. There is no registered output path.

## Structure
- **Package `alu_pkg`**
  - localparams for the ten ALU control codes, shared with the ALU control decoder.
  - Engine state enum (IDLE, RUN, FIN).
  - `DATA_W` default.
- **Sub-module `muldiv_seq`**
  - Contains: FSM, counter, shift/accumulate datapath, sign fix-up, HI/LO registers, busy/done/div_by_zero.
  - Exports HI/LO to the parent.
- **Top `alu_hilo`**: combinational op mux, `zero` flag, and instantiation of `muldiv_seq`.

## Test plan
1. Combinational ops:
   - ADD 0x7FFFFFFF + 1 → 0x80000000, `zero` = 0.
   - SUB 5 − 5 → 0, `zero` = 1.
   - SLT 0xFFFFFFFF, 1 → 1.
   - NOR 0, 0 → 0xFFFFFFFF.
   - Code 1111 → 0.
2. MULT −3 × 7 with `start`:
   - `busy` = 1 the next cycle.
   - `done` 34 cycles after start.
   - Then MFLO → 0xFFFFFFEB, MFHI → 0xFFFFFFFF.
3. DIV −7 / 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → LO 0x80000000, HI 0.
4. DIV 9 / 0:
   - `done` and `div_by_zero` pulse the next cycle.
   - `busy` stays 0.
   - HI/LO keep their prior values.
5. Start handling:
   - `start` MULT while busy is ignored, and the result matches the first operation.
   - MFHI during busy returns the old HI.
   - A new MULT started in the `done` cycle completes 34 cycles later.
6. Reset mid-operation:
   - Assert `rst` at iteration 10, asynchronously between edges.
   - `busy` and HI/LO read 0 immediately.
   - After release, a new MULT 2 × 3 → LO 6, HI 0.
